shift_sipo_master: RTL
======================

Name: shift_sipo_master

Overview:
- Serial-in/parallel-out receive shifter for the I2C master; it is the read-direction counterpart of the master's parallel-load transmit shifter.
- Samples SDA MSB-first on bit strobes from the bus controller and assembles a byte.
- Presents the byte with a one-cycle valid pulse, then drives the master ACK/NACK bit during the 9th SCL clock.
- Sits between the SCL/SDA bus controller and the master's data path.

Parameters:
- DATA_W, 8, bits per received byte. Only 8 is required for I2C; must be at least 2.
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Rst  in  1  synchronous active-high reset.
- Start  in  1  begin receiving one byte; sampled only in IDLE.
- Last  in  1  latched with Start; 1 = NACK this byte (final read), 0 = ACK.
- Stop  in  1  abort (STOP seen or arbitration lost); highest priority after Rst.
- Bit_En  in  1  one-cycle strobe at each SCL-high sample point.
- Sda_In  in  1  synchronized SDA level.
- Rd  in  1  consumer has taken Out (used only with the optional feature).
- Out  out  DATA_W  last completed byte.
- Valid  out  1  one-cycle pulse, Out newly updated.
- Busy  out  1  high in SHIFT and ACK.
- Sda_Oe  out  1  1 = pull SDA low (ACK).
- Overrun  out  1  sticky overrun flag (optional feature).

Behaviour:
- Reset (synchronous, Rst=1 at posedge):
  - State=IDLE; shift reg=0; Cont=0; last_q=0.
  - Out=0, Valid=0, Busy=0, Sda_Oe=0, Overrun=0.
  - Rst wins over every other input, including mid-byte and mid-ACK.
- All outputs are registered.
- IDLE:
  - Start=1 -> SHIFT; Cont=0; shift reg=0; last_q<=Last.
  - Bit_En in IDLE is ignored, including on the same cycle as Start. The first bit is taken on the next Bit_En.
- SHIFT, on each Bit_En:
  - shift reg <= {shift reg[DATA_W-2:0], Sda_In}; Cont <= Cont+1.
  - On the DATA_W-th Bit_En (Cont==DATA_W-1):
    - Out <= {shift reg[DATA_W-2:0], Sda_In}.
    - Valid <= 1 for exactly one cycle.
    - Sda_Oe <= !last_q.
    - Cont <= 0; state -> ACK.
  - Latency: Out and Valid are visible the cycle after the final Bit_En.
- ACK:
  - Sda_Oe holds its value.
  - The first Bit_En -> IDLE, Sda_Oe <= 0.
  - Start in ACK is ignored; the controller re-issues it in IDLE.
- Stop=1 in SHIFT or ACK:
  - Next state IDLE; Sda_Oe <= 0; Cont <= 0.
  - No Valid is generated; Out keeps its previous value.
  - Stop in IDLE has no effect.
  - Stop and Bit_En on the same cycle: Stop wins, no shift.
- Start while Busy: ignored.
- Cont never exceeds DATA_W-1; there is no wrap-around path.
- Busy = (state != IDLE), registered together with the state.
- Out is stable between Valid pulses.

Optional Feature:
- Macro: SHIFT_SIPO_OVERRUN_EN.
- With the macro:
  - Internal pending flag is set on Valid and cleared on Rd.
  - Valid while pending is still set (and no Rd that cycle) -> Overrun <= 1, sticky until Rst. Out is still overwritten.
  - Rd and Valid on the same cycle: pending stays 1, no overrun.
- Without the macro:
  - Overrun is tied to 0.
  - Rd is ignored.
  - No pending logic is synthesized.

Decomposition:
- Package i2c_pkg holds:
  - State encoding (IDLE=2'd0, SHIFT=2'd1, ACK=2'd2).
  - I2C_DATA_W=8.
  - I2C_ACK=1'b0 and I2C_NACK=1'b1 bus-level constants.
- One sub-module is natural: i2c_bit_cnt. It is a CNT_W counter with clear, enable and a terminal-count output at DATA_W-1, reusable by the transmit shifter.
- The FSM and shift register stay in shift_sipo_master.

Test Plan:
- Basic receive with ACK:
  - Stimulus: Rst 2 cycles; Start with Last=0; 8 Bit_En carrying 1,0,1,0,0,1,0,1.
  - Response: Out=8'hA5; Valid high exactly 1 cycle, one cycle after the 8th strobe; Sda_Oe=1 until the 9th Bit_En, then 0; Busy falls with it.
- NACK on final byte:
  - Stimulus: Start with Last=1; receive 8'h3C.
  - Response: Out=8'h3C, Valid pulse, Sda_Oe stays 0 throughout ACK.
- Abort mid-byte:
  - Stimulus: Stop after 4 bits of 8'hFF.
  - Response: IDLE next cycle; no Valid; Out unchanged (previous 8'h3C); Sda_Oe=0.
  - Follow-up: new Start receiving 8'h81 yields Out=8'h81 (no stale bits).
- Mid-operation reset and ignored inputs:
  - Stimulus: Rst during ACK.
  - Response: next cycle Sda_Oe=0, Out=0, Busy=0.
  - Stimulus: Start+Bit_En on the same cycle, Sda_In=1, then 8 strobes of 8'h00.
  - Response: Out=8'h00 (the coincident strobe was ignored).
- Overrun (SHIFT_SIPO_OVERRUN_EN defined):
  - Stimulus: receive 8'h11 and 8'h22 without Rd.
  - Response: Overrun=1 after the second Valid; Out=8'h22.
  - Stimulus: repeat after Rst, asserting Rd on the same cycle as the second Valid.
  - Response: Overrun stays 0.
  - Stimulus: same sequence without the macro.
  - Response: Overrun stays 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: receive-shifter state encoding,
// default byte width and bus-level ACK/NACK values.
package i2c_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      ACK   = 2'd2
   } sipo_state_e;

   localparam int I2C_DATA_W = 8;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_bit_cnt.sv
// Bit counter with clear, enable and terminal count at DATA_W-1,
// shared by the I2C master receive and transmit shifters.
module i2c_bit_cnt #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             tc_o
);

   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DATA_W - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == TC_VAL);

endmodule

// File: rtl/shift_sipo_master.sv
// I2C master receive shifter: MSB-first SIPO with ACK/NACK drive.
// Define SHIFT_SIPO_OVERRUN_EN to enable Rd/pending overrun tracking.
module shift_sipo_master
   import i2c_pkg::*;
#(
   parameter int DATA_W = I2C_DATA_W,
   parameter int CNT_W  = 4
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Start,
   input  logic              Last,
   input  logic              Stop,
   input  logic              Bit_En,
   input  logic              Sda_In,
   input  logic              Rd,
   output logic [DATA_W-1:0] Out,
   output logic              Valid,
   output logic              Busy,
   output logic              Sda_Oe,
   output logic              Overrun
);

   sipo_state_e       state_q;
   logic [DATA_W-1:0] shreg_q;
   logic [DATA_W-1:0] shreg_d;
   logic [DATA_W-1:0] out_q;
   logic              last_q;
   logic              valid_q;
   logic              busy_q;
   logic              oe_q;
   logic              abort;
   logic              cnt_clr;
   logic              cnt_en;
   logic              tc;
   logic [CNT_W-1:0]  cnt;

   assign shreg_d = {shreg_q[DATA_W-2:0], Sda_In};
   assign abort   = Stop && (state_q != IDLE);
   assign cnt_en  = (state_q == SHIFT) && Bit_En && !Stop;
   assign cnt_clr = abort
                 || ((state_q == IDLE) && Start)
                 || (cnt_en && tc);

   i2c_bit_cnt #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_cnt (
      .clk_i (Clk),
      .rst_i (Rst),
      .clr_i (cnt_clr),
      .en_i  (cnt_en),
      .cnt_o (cnt),
      .tc_o  (tc)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         out_q   <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         oe_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            oe_q    <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (Start) begin
                     state_q <= SHIFT;
                     busy_q  <= 1'b1;
                     shreg_q <= '0;
                     last_q  <= Last;
                  end
               end
               SHIFT: begin
                  if (Bit_En) begin
                     shreg_q <= shreg_d;
                     if (tc) begin
                        out_q   <= shreg_d;
                        valid_q <= 1'b1;
                        oe_q    <= (last_q != I2C_NACK);
                        state_q <= ACK;
                     end
                  end
               end
               ACK: begin
                  if (Bit_En) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     oe_q    <= 1'b0;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  oe_q    <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef SHIFT_SIPO_OVERRUN_EN
   logic pend_q;
   logic ovr_q;

   // Rd coinciding with Valid acknowledges the old byte, not the new one
   always_ff @(posedge Clk) begin
      if (Rst) begin
         pend_q <= 1'b0;
         ovr_q  <= 1'b0;
      end else if (valid_q) begin
         pend_q <= 1'b1;
         if (pend_q && !Rd)
            ovr_q <= 1'b1;
      end else if (Rd) begin
         pend_q <= 1'b0;
      end
   end

   assign Overrun = ovr_q;
`else
   assign Overrun = 1'b0;
`endif

   assign Out    = out_q;
   assign Valid  = valid_q;
   assign Busy   = busy_q;
   assign Sda_Oe = oe_q;

endmodule
